jtag_dtm_param: RTL

JTAG_DTM_PARAM -- requirements
Module: jtag_dtm_param

---
 rtl/jtag_dtm_param_pkg.sv | 32 +++
 rtl/jtag_dtm_param_tap_fsm.sv | 37 +++
 rtl/jtag_dtm_param.sv | 102 ++++++++++
 3 files changed

// File: rtl/jtag_dtm_param_pkg.sv
// jtag: TAP state encoding, IR instruction codes and DMI op/status constants
package jtag;
    typedef logic [3:0] jtag_state_t;
    localparam jtag_state_t TEST_LOGIC_RESET = 4'd0;
    localparam jtag_state_t RUN_TEST_IDLE    = 4'd1;
    localparam jtag_state_t SELECT_DR_SCAN   = 4'd2;
    localparam jtag_state_t CAPTURE_DR       = 4'd3;
    localparam jtag_state_t SHIFT_DR         = 4'd4;
    localparam jtag_state_t EXIT1_DR         = 4'd5;
    localparam jtag_state_t PAUSE_DR         = 4'd6;
    localparam jtag_state_t EXIT2_DR         = 4'd7;
    localparam jtag_state_t UPDATE_DR        = 4'd8;
    localparam jtag_state_t SELECT_IR_SCAN   = 4'd9;
    localparam jtag_state_t CAPTURE_IR       = 4'd10;
    localparam jtag_state_t SHIFT_IR         = 4'd11;
    localparam jtag_state_t EXIT1_IR         = 4'd12;
    localparam jtag_state_t PAUSE_IR         = 4'd13;
    localparam jtag_state_t EXIT2_IR         = 4'd14;
    localparam jtag_state_t UPDATE_IR        = 4'd15;
    // IR codes are truncated to the instance IR width; BYPASS is all ones
    localparam logic [31:0] IR_IDCODE = 32'h01;
    localparam logic [31:0] IR_DTMCS  = 32'h10;
    localparam logic [31:0] IR_DMI    = 32'h11;
    localparam logic [31:0] IR_BYPASS = 32'hFFFF_FFFF;
    typedef enum logic [1:0] {SEL_BYPASS, SEL_IDCODE, SEL_DTMCS, SEL_DMI} dr_sel_t;
    localparam logic [1:0] DMI_OP_NOP      = 2'd0;
    localparam logic [1:0] DMI_OP_READ     = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE    = 2'd2;
    localparam logic [1:0] DMI_STAT_OK     = 2'd0;
    localparam logic [1:0] DMI_STAT_FAILED = 2'd2;
    localparam logic [1:0] DMI_STAT_BUSY   = 2'd3;
endpackage

// File: rtl/jtag_dtm_param_tap_fsm.sv
// jtag_tap_fsm: IEEE 1149.1 TAP controller state register
module jtag_tap_fsm
    import jtag::*;
(
    input  logic        tclk,
    input  logic        trst,
    input  logic        tms,
    output jtag_state_t state
);
    jtag_state_t r_state, w_next;

    always_comb begin
        w_next = TEST_LOGIC_RESET;
        case (r_state)
            TEST_LOGIC_RESET: w_next = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    w_next = tms ? SELECT_DR_SCAN : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   w_next = tms ? SELECT_IR_SCAN : CAPTURE_DR;
            CAPTURE_DR:       w_next = tms ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR:         w_next = tms ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR:         w_next = tms ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:         w_next = tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR:         w_next = tms ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:        w_next = tms ? SELECT_DR_SCAN : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   w_next = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       w_next = tms ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR:         w_next = tms ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR:         w_next = tms ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:         w_next = tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR:         w_next = tms ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:        w_next = tms ? SELECT_DR_SCAN : RUN_TEST_IDLE;
        endcase
    end

    always_ff @(posedge tclk) r_state <= trst ? TEST_LOGIC_RESET : w_next;

    assign state = r_state;
endmodule

// File: rtl/jtag_dtm_param.sv
// jtag_dtm_param: RISC-V style JTAG debug transport module with IDCODE,
// DTMCS, DMI and BYPASS chains driving a strobed DMI request interface
module jtag_dtm_param
    import jtag::*;
#(
    parameter int unsigned IR_WIDTH   = 6,
    parameter logic [31:0] IDCODE_VAL = 32'h1BEEF001,
    parameter int unsigned ABITS      = 7,
    parameter logic [2:0]  IDLE_HINT  = 3'd1
) (
    input  logic             tclk,
    input  logic             trst,
    input  logic             tms,
    input  logic             tdi,
    output logic             tdo,
    output logic             tdo_en,
    output logic             dmi_start,
    input  logic             dmi_finish,
    output logic [1:0]       dmi_op,
    output logic [ABITS-1:0] dmi_address,
    output logic [31:0]      dmi_data_o,
    input  logic [31:0]      dmi_data_i,
    input  logic [1:0]       dmi_resp
);
    localparam int unsigned DR_W    = ABITS + 34;
    localparam logic [5:0]  ABITS_F = 6'(ABITS);

    jtag_state_t         w_state;
    dr_sel_t             w_sel;
    logic [IR_WIDTH-1:0] r_ir, r_ir_sh;
    logic [DR_W-1:0]     r_dr, w_dr_cap, w_dr_shift;
    logic                r_busy, r_start;
    logic [1:0]          r_stat, r_op, w_op_field;
    logic [ABITS-1:0]    r_addr;
    logic [31:0]         r_data, r_data_last;
    logic                w_dmi_upd, w_dtmcs_upd, w_req_ok;

    jtag_tap_fsm u_fsm (.tclk(tclk), .trst(trst), .tms(tms), .state(w_state));

    assign w_sel = (r_ir == IR_WIDTH'(IR_IDCODE)) ? SEL_IDCODE :
                   (r_ir == IR_WIDTH'(IR_DTMCS))  ? SEL_DTMCS  :
                   (r_ir == IR_WIDTH'(IR_DMI))    ? SEL_DMI    : SEL_BYPASS;
    assign w_op_field = r_busy ? DMI_STAT_BUSY : r_stat;
    assign w_dr_cap = (w_sel == SEL_IDCODE) ? DR_W'(IDCODE_VAL) :
                      (w_sel == SEL_DTMCS)  ? DR_W'({14'b0, 2'b0, 1'b0, IDLE_HINT, r_stat, ABITS_F, 4'd1}) :
                      (w_sel == SEL_DMI)    ? {r_addr, r_data_last, w_op_field} : '0;
    // Each chain shifts at its own length: tdi always enters the chain's MSB
    assign w_dr_shift = (w_sel == SEL_DMI)    ? {tdi, r_dr[DR_W-1:1]} :
                        (w_sel == SEL_BYPASS) ? DR_W'(tdi) : DR_W'({tdi, r_dr[31:1]});
    assign tdo_en = !trst && (w_state == SHIFT_DR || w_state == SHIFT_IR);
    assign tdo = tdo_en && ((w_state == SHIFT_DR) ? r_dr[0] : r_ir_sh[0]);
    assign w_dmi_upd = (w_state == UPDATE_DR) && (w_sel == SEL_DMI);
    assign w_dtmcs_upd = (w_state == UPDATE_DR) && (w_sel == SEL_DTMCS);
    assign w_req_ok = !r_busy && (r_stat == DMI_STAT_OK) &&
                      (r_dr[1:0] == DMI_OP_READ || r_dr[1:0] == DMI_OP_WRITE);

    always_ff @(posedge tclk) begin
        if (trst || w_state == TEST_LOGIC_RESET) r_ir <= IR_WIDTH'(IR_IDCODE);
        else if (w_state == UPDATE_IR) r_ir <= r_ir_sh;
        if (trst) r_ir_sh <= '0;
        else if (w_state == CAPTURE_IR) r_ir_sh <= IR_WIDTH'(2'b01);
        else if (w_state == SHIFT_IR) r_ir_sh <= {tdi, r_ir_sh[IR_WIDTH-1:1]};
        if (trst) r_dr <= '0;
        else if (w_state == CAPTURE_DR) r_dr <= w_dr_cap;
        else if (w_state == SHIFT_DR) r_dr <= w_dr_shift;
    end

    // A TAP-driven TEST_LOGIC_RESET leaves the DMI side alone; only trst clears it
    always_ff @(posedge tclk) begin
        if (trst) begin
            r_busy      <= 1'b0;
            r_start     <= 1'b0;
            r_stat      <= DMI_STAT_OK;
            r_op        <= DMI_OP_NOP;
            r_addr      <= '0;
            r_data      <= '0;
            r_data_last <= '0;
        end else begin
            r_start <= 1'b0;
            if (r_busy && dmi_finish) begin
                r_busy      <= 1'b0;
                r_data_last <= dmi_data_i;
                if (dmi_resp == DMI_STAT_FAILED) r_stat <= DMI_STAT_FAILED;
            end
            if (w_dmi_upd && r_busy) r_stat <= DMI_STAT_BUSY;
            else if (w_dmi_upd && w_req_ok) begin
                r_start <= 1'b1;
                r_busy  <= 1'b1;
                r_op    <= r_dr[1:0];
                r_data  <= r_dr[33:2];
                r_addr  <= r_dr[DR_W-1:34];
            end
            if (w_dtmcs_upd && (r_dr[16] || r_dr[17])) r_stat <= DMI_STAT_OK;
            if (w_dtmcs_upd && r_dr[17]) r_busy <= 1'b0;
        end
    end

    assign dmi_start   = r_start;
    assign dmi_op      = r_op;
    assign dmi_address = r_addr;
    assign dmi_data_o  = r_data;
endmodule
